// File: rtl/pixel_bus_sink.sv
// Drawer-bus pixel sink: clips strobed pixels to 160x120, queues {addr,color} and drains to the framebuffer.
// Define PIXEL_SINK_CLEAR_EN to build the full-screen clear engine (S_CLEAR state and address counter).
module pixel_bus_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int COLOR_BITS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vga_draw_enable_bus,
    input  logic [7:0]                    vga_x_out_bus,
    input  logic [7:0]                    vga_y_out_bus,
    input  logic [23:0]                   vga_RGB_out_bus,
    output logic [14:0]                   fb_addr,
    output logic [3*COLOR_BITS-1:0]       fb_data,
    output logic                          fb_we,
    input  logic                          fb_busy,
    input  logic                          clear,
    input  logic [23:0]                   clear_color,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    drop_count,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 3*COLOR_BITS;
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

    typedef struct packed {
        logic [14:0]   addr;
        logic [CW-1:0] color;
    } pix_t;

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    function automatic logic [CW-1:0] reduce(input logic [23:0] rgb);
        return {rgb[23 -: COLOR_BITS], rgb[15 -: COLOR_BITS], rgb[7 -: COLOR_BITS]};
    endfunction

    logic          in_range, push_req, push, pop;
    logic [14:0]   x_ext, y_ext;
    pix_t          pix_in;
    pix_t          mem_q [FIFO_DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [14:0]   fb_addr_q, fb_addr_d;
    logic [CW-1:0] fb_data_q, fb_data_d;
    logic          fb_we_q, fb_we_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_q, drop_d;
    logic          busy_q, busy_d;
`ifdef PIXEL_SINK_CLEAR_EN
    logic [14:0]   clr_cnt_q, clr_cnt_d;
    logic [CW-1:0] clr_color_q, clr_color_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{vga_RGB_out_bus, clear_color, clear};

    always_comb begin
        x_ext         = {7'b0, vga_x_out_bus};
        y_ext         = {7'b0, vga_y_out_bus};
        in_range      = (vga_x_out_bus < 8'd160) && (vga_y_out_bus < 8'd120);
        pix_in.addr   = (y_ext << 7) + (y_ext << 5) + x_ext;
        pix_in.color  = reduce(vga_RGB_out_bus);
        // A strobe of x/z never evaluates true, so a floating bus never pushes.
        push_req      = vga_draw_enable_bus && in_range;
        pop           = (level_q != '0) && !fb_busy && (state_q == S_RUN);
        push          = push_req && ((level_q != DEPTH_L) || pop);

        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        level_d       = level_q;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        fb_we_d       = 1'b0;
        overflow_d    = overflow_q;
        drop_d        = drop_q;
`ifdef PIXEL_SINK_CLEAR_EN
        clr_cnt_d     = clr_cnt_q;
        clr_color_d   = clr_color_q;
`endif

        if (vga_draw_enable_bus && !in_range && (drop_q != 8'hFF))
            drop_d = drop_q + 1'b1;
        if (push_req && !push)
            overflow_d = 1'b1;
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            fb_we_d   = 1'b1;
            fb_addr_d = mem_q[rd_ptr_q].addr;
            fb_data_d = mem_q[rd_ptr_q].color;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

`ifdef PIXEL_SINK_CLEAR_EN
        case (state_q)
            S_RUN: begin
                if (clear) begin
                    state_d     = S_CLEAR;
                    clr_cnt_d   = '0;
                    clr_color_d = reduce(clear_color);
                end
            end
            S_CLEAR: begin
                // The queue is frozen here; captured pixels wait until the sweep ends.
                if (!fb_busy) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = clr_cnt_q;
                    fb_data_d = clr_color_q;
                    clr_cnt_d = clr_cnt_q + 15'd1;
                    if (clr_cnt_q == 15'd19199) begin
                        state_d   = S_RUN;
                        clr_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
`endif

        busy_d = (state_d == S_CLEAR) || (level_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            fb_we_q     <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
            busy_q      <= 1'b0;
`ifdef PIXEL_SINK_CLEAR_EN
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            fb_we_q     <= fb_we_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
`ifdef PIXEL_SINK_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= pix_in;
    end

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pixel_bus_sink.sv
// Bench for pixel_bus_sink: directed corner cases plus random traffic against a queue-based reference model.
module tb_pixel_bus_sink;
    localparam int DEPTH = 8;
    localparam int CB    = 3;
    localparam int CW    = 3*CB;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PIXEL_SINK_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          strobe = 1'b0;
    logic [7:0]    x = '0, y = '0;
    logic [23:0]   rgb = '0;
    logic          fb_busy = 1'b0;
    logic          clear = 1'b0;
    logic [23:0]   clear_color = '0;
    logic [14:0]   fb_addr;
    logic [CW-1:0] fb_data;
    logic          fb_we;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          busy;

    pixel_bus_sink #(.FIFO_DEPTH(DEPTH), .COLOR_BITS(CB)) dut (
        .clk(clk), .reset(reset),
        .vga_draw_enable_bus(strobe), .vga_x_out_bus(x), .vga_y_out_bus(y), .vga_RGB_out_bus(rgb),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_busy(fb_busy),
        .clear(clear), .clear_color(clear_color),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Reference model: a plain queue of pending writes plus the observable registers.
    typedef struct {
        int            a;
        logic [CW-1:0] d;
    } ent_t;

    ent_t          q[$];
    bit            m_we, m_ovf, m_busy, m_clr_on;
    int            m_addr, m_drop, m_clr_idx;
    logic [CW-1:0] m_data, m_clr_data;

    function automatic logic [CW-1:0] m_reduce(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]) >> (8 - CB);
        g = int'(c[15:8])  >> (8 - CB);
        b = int'(c[7:0])   >> (8 - CB);
        return CW'((r << (2*CB)) | (g << CB) | b);
    endfunction

    task automatic model_reset();
        q.delete();
        m_we = 0; m_ovf = 0; m_busy = 0; m_clr_on = 0;
        m_addr = 0; m_drop = 0; m_clr_idx = 0;
        m_data = '0; m_clr_data = '0;
    endtask

    task automatic model_edge();
        ent_t e;
        int   px, py;
        if (reset) begin
            model_reset();
            return;
        end
        m_we = 0;
        if (m_clr_on) begin
            if (!fb_busy) begin
                m_we = 1; m_addr = m_clr_idx; m_data = m_clr_data;
                if (m_clr_idx == 19199) m_clr_on = 0;
                else m_clr_idx++;
            end
        end else begin
            if (q.size() > 0 && !fb_busy) begin
                e = q.pop_front();
                m_we = 1; m_addr = e.a; m_data = e.d;
            end
            if (CLR_EN && clear) begin
                m_clr_on = 1; m_clr_idx = 0; m_clr_data = m_reduce(clear_color);
            end
        end
        if (strobe === 1'b1) begin
            px = int'(x);
            py = int'(y);
            if (px < 160 && py < 120) begin
                if (q.size() < DEPTH) begin
                    e.a = py*160 + px;
                    e.d = m_reduce(rgb);
                    q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        m_busy = m_clr_on || (q.size() > 0);
    endtask

    task automatic cmp_all();
        chk("we",    fb_we,      m_we);
        chk("addr",  fb_addr,    m_addr);
        chk("data",  fb_data,    m_data);
        chk("level", fifo_level, q.size());
        chk("ovf",   overflow,   m_ovf);
        chk("drop",  drop_count, m_drop);
        chk("busy",  busy,       m_busy);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic drv(input bit s, input int px, input int py, input logic [23:0] c, input bit b);
        strobe = s; x = 8'(px); y = 8'(py); rgb = c; fb_busy = b;
        step();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        cmp_all();
        chk("rst_we",    fb_we, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy",  busy, 0);
        strobe = 0; fb_busy = 0; clear = 0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int nwr, pct;
        model_reset();
        step();
        step();
        chk("init_we", fb_we, 0);
        chk("init_level", fifo_level, 0);
        reset = 1'b0;

        // Single pixel: two-cycle latency, address and reduced color.
        drv(1, 5, 2, 24'hFF8000, 0);
        drv(0, 0, 0, 24'h0, 0);
        chk("px_we", fb_we, 1);
        chk("px_addr", fb_addr, 325);
        chk("px_data", fb_data, 9'b111_100_000);

        drv(1, 159, 119, $urandom, 0);
        drv(0, 0, 0, 24'h0, 0);
        chk("corner_addr", fb_addr, 19199);

        drv(1, 160, 0, $urandom, 0);
        drv(0, 0, 0, 24'h0, 0);
        chk("drop_one", drop_count, 1);
        chk("drop_nowr", fb_we, 0);

        for (int i = 0; i < 300; i++)
            drv(1, (i % 2) ? 160 + $urandom_range(0, 95) : $urandom_range(0, 159),
                (i % 2) ? $urandom_range(0, 255) : 120 + $urandom_range(0, 135), $urandom, 0);
        chk("drop_sat", drop_count, 255);

        // Stalled framebuffer: 9 pixels into an 8-deep queue, then drain in order.
        for (int i = 0; i < 9; i++) drv(1, i, 3, $urandom, 1);
        chk("full_level", fifo_level, 8);
        chk("full_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 0, 24'h0, 0);
            chk("ord_we", fb_we, 1);
            chk("ord_addr", fb_addr, 480 + i);
        end
        drv(0, 0, 0, 24'h0, 0);
        chk("ord_end_we", fb_we, 0);
        chk("ovf_sticky", overflow, 1);

        // Full queue accepts a push in the same cycle as a pop.
        for (int i = 0; i < 8; i++) drv(1, 10 + i, 4, $urandom, 1);
        drv(1, 50, 4, $urandom, 0);
        chk("fullpop_level", fifo_level, 8);
        for (int i = 0; i < 12; i++) drv(0, 0, 0, 24'h0, 0);

`ifdef PIXEL_SINK_CLEAR_EN
        clear = 1; clear_color = 24'h000000;
        drv(0, 0, 0, 24'h0, 0);
        clear = 0;
        nwr = 0;
        for (int c = 0; c < 25000 && m_busy; c++) begin
            clear   = (c == 50);
            strobe  = (c == 100);
            x = 8'd7; y = 8'd7; rgb = 24'hFFFFFF;
            fb_busy = ($urandom_range(0, 7) == 0);
            step();
            if (fb_we) nwr++;
        end
        clear = 0; strobe = 0; fb_busy = 0;
        chk("clr_writes", nwr, 19201);
        chk("clr_last_addr", fb_addr, 7*160 + 7);
        chk("clr_busy_end", busy, 0);

        clear = 1;
        drv(0, 0, 0, 24'h0, 0);
        clear = 0;
        for (int i = 0; i < 3; i++) drv(1, i, 9, $urandom, 0);
`else
        for (int i = 0; i < 3; i++) drv(1, i, 9, $urandom, 1);
`endif
        chk("pre_rst_level", fifo_level, 3);
        async_reset();
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 0, 24'h0, 0);
            chk("post_rst_nowr", fb_we, 0);
        end

        // Random traffic with varying back-pressure.
        pct = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) pct = $urandom_range(0, 3) * 30;
            strobe  = ($urandom_range(0, 1) == 1);
            x       = 8'($urandom_range(0, 175));
            y       = 8'($urandom_range(0, 130));
            rgb     = 24'($urandom);
            fb_busy = ($urandom_range(0, 99) < pct);
            clear   = CLR_EN ? 1'b0 : 1'($urandom);
            clear_color = 24'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
